// File: rtl/yin_tau_picker_pkg.sv
// Shared types and constants for the YIN period picker.
package yin_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    DIP,
    LOCKED
  } yin_state_e;

  localparam int unsigned TAU_WIDTH   = 11;
  localparam int unsigned THRESH_FRAC = 8;
  localparam logic [TAU_WIDTH-1:0] TAU_MAX = '1;

  // Running sum of up to 2^TAU_WIDTH-1 lags can never wrap at this width.
  function automatic int unsigned sum_width(input int unsigned diff_width);
    return diff_width + TAU_WIDTH;
  endfunction

endpackage

// File: rtl/yin_tau_picker_cmndf_compare.sv
// Two-stage CMNDF threshold test: (d*t) << THRESH_FRAC < THRESH * S(t), evaluated without division.
module cmndf_compare
  import yin_pkg::*;
#(
  parameter int unsigned DIFF_WIDTH = 40,
  parameter int unsigned THRESH     = 38
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           p0_valid,
  input  logic                           p0_eval,
  input  logic [DIFF_WIDTH-1:0]          p0_d,
  input  logic [TAU_WIDTH-1:0]           p0_t,
  input  logic [sum_width(DIFF_WIDTH)-1:0] p0_s,
  input  logic                           p0_last,
  output logic                           p2_valid,
  output logic                           p2_eval,
  output logic [DIFF_WIDTH-1:0]          p2_d,
  output logic [TAU_WIDTH-1:0]           p2_t,
  output logic                           p2_last,
  output logic                           below_thresh
);

  localparam int unsigned SUM_WIDTH = sum_width(DIFF_WIDTH);
  localparam int unsigned CMP_WIDTH = SUM_WIDTH + THRESH_FRAC;

  logic                  p1_valid, p1_eval, p1_last;
  logic [DIFF_WIDTH-1:0] p1_d;
  logic [TAU_WIDTH-1:0]  p1_t;
  logic [SUM_WIDTH-1:0]  p1_s;
  logic [CMP_WIDTH-1:0]  lhs_c, rhs_c, p2_lhs, p2_rhs;

  assign lhs_c = (CMP_WIDTH'(p1_d) * CMP_WIDTH'(p1_t)) << THRESH_FRAC;
  assign rhs_c = CMP_WIDTH'(THRESH) * CMP_WIDTH'(p1_s);

  // P1: capture the beat with its lag index and running sum.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      p1_valid <= 1'b0;
      p1_eval  <= 1'b0;
      p1_last  <= 1'b0;
      p1_d     <= '0;
      p1_t     <= '0;
      p1_s     <= '0;
    end else begin
      p1_valid <= p0_valid;
      p1_eval  <= p0_eval;
      p1_last  <= p0_last;
      p1_d     <= p0_d;
      p1_t     <= p0_t;
      p1_s     <= p0_s;
    end
  end

  // P2: register both sides of the threshold inequality.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      p2_valid <= 1'b0;
      p2_eval  <= 1'b0;
      p2_last  <= 1'b0;
      p2_d     <= '0;
      p2_t     <= '0;
      p2_lhs   <= '0;
      p2_rhs   <= '0;
    end else begin
      p2_valid <= p1_valid;
      p2_eval  <= p1_eval;
      p2_last  <= p1_last;
      p2_d     <= p1_d;
      p2_t     <= p1_t;
      p2_lhs   <= lhs_c;
      p2_rhs   <= rhs_c;
    end
  end

  // Strict compare; S=0 gives rhs=0 and therefore never passes.
  assign below_thresh = p2_lhs < p2_rhs;

endmodule

// File: rtl/yin_tau_picker.sv
// Picks one pitch period per window from a stream of YIN difference values.
module yin_tau_picker
  import yin_pkg::*;
#(
  parameter int unsigned DIFF_WIDTH = 40,
  parameter int unsigned TAU_MIN    = 20,
  parameter int unsigned THRESH     = 38
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DIFF_WIDTH-1:0] diff_in,
  input  logic                  diff_valid_in,
  input  logic                  diff_last_in,
  output logic [TAU_WIDTH-1:0]  tau_out,
  output logic                  tau_valid_out,
  output logic                  voiced_out
);

  localparam int unsigned SUM_WIDTH = sum_width(DIFF_WIDTH);

  logic [TAU_WIDTH-1:0]  lag_q;
  logic                  sat_q;
  logic [SUM_WIDTH-1:0]  sum_q, sum_c;

  logic                  p2_valid, p2_eval, p2_last, below_thresh;
  logic [DIFF_WIDTH-1:0] p2_d;
  logic [TAU_WIDTH-1:0]  p2_t;

  yin_state_e            state_q, state_n;
  logic [DIFF_WIDTH-1:0] dip_min_q, dip_min_n, g_min_q, g_min_n;
  logic [TAU_WIDTH-1:0]  dip_tau_q, dip_tau_n, g_tau_q, g_tau_n;
  logic                  g_seen_q, g_seen_n;
  logic                  cand, emit;
  logic [TAU_WIDTH-1:0]  emit_tau;
  logic                  emit_voiced;

  // Beats past lag 2047 carry no data; only their last flag is honoured.
  assign sum_c = sat_q ? sum_q : sum_q + SUM_WIDTH'(diff_in);

  // Lag counter and running sum, restarted after each window's last beat.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      lag_q <= TAU_WIDTH'(1);
      sat_q <= 1'b0;
      sum_q <= '0;
    end else if (diff_valid_in) begin
      if (diff_last_in) begin
        lag_q <= TAU_WIDTH'(1);
        sat_q <= 1'b0;
        sum_q <= '0;
      end else begin
        sum_q <= sum_c;
        if (!sat_q) begin
          if (lag_q == TAU_MAX) sat_q <= 1'b1;
          else                  lag_q <= lag_q + TAU_WIDTH'(1);
        end
      end
    end
  end

  cmndf_compare #(
    .DIFF_WIDTH (DIFF_WIDTH),
    .THRESH     (THRESH)
  ) u_cmp (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .p0_valid     (diff_valid_in),
    .p0_eval      (!sat_q),
    .p0_d         (diff_in),
    .p0_t         (lag_q),
    .p0_s         (sum_c),
    .p0_last      (diff_last_in),
    .p2_valid     (p2_valid),
    .p2_eval      (p2_eval),
    .p2_d         (p2_d),
    .p2_t         (p2_t),
    .p2_last      (p2_last),
    .below_thresh (below_thresh)
  );

  assign cand = p2_valid && p2_eval && (p2_t >= TAU_WIDTH'(TAU_MIN));
  assign emit = p2_valid && p2_last;

  // Next state and trackers; the emit value is taken from the post-update view so the last lag counts.
  always_comb begin
    state_n   = state_q;
    dip_min_n = dip_min_q;
    dip_tau_n = dip_tau_q;
    g_min_n   = g_min_q;
    g_tau_n   = g_tau_q;
    g_seen_n  = g_seen_q;
    if (cand) begin
      if (!g_seen_q || (p2_d < g_min_q)) begin
        g_min_n  = p2_d;
        g_tau_n  = p2_t;
        g_seen_n = 1'b1;
      end
      case (state_q)
        SEARCH: if (below_thresh) begin
          state_n   = DIP;
          dip_min_n = p2_d;
          dip_tau_n = p2_t;
        end
        DIP: begin
          if (p2_d < dip_min_q) begin
            dip_min_n = p2_d;
            dip_tau_n = p2_t;
          end else if (p2_d > dip_min_q) begin
            state_n = LOCKED;
          end
        end
        LOCKED:  state_n = LOCKED;
        default: state_n = SEARCH;
      endcase
    end
    emit_voiced = (state_n != SEARCH);
    if (state_n != SEARCH) emit_tau = dip_tau_n;
    else if (g_seen_n)     emit_tau = g_tau_n;
    else                   emit_tau = TAU_WIDTH'(TAU_MIN);
  end

  // FSM state register, returned to SEARCH when a window is emitted.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)   state_q <= SEARCH;
    else if (emit) state_q <= SEARCH;
    else           state_q <= state_n;
  end

  // Dip and global-minimum trackers, cleared when a window is emitted.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dip_min_q <= '0;
      dip_tau_q <= '0;
      g_min_q   <= '0;
      g_tau_q   <= '0;
      g_seen_q  <= 1'b0;
    end else if (emit) begin
      dip_min_q <= '0;
      dip_tau_q <= '0;
      g_min_q   <= '0;
      g_tau_q   <= '0;
      g_seen_q  <= 1'b0;
    end else begin
      dip_min_q <= dip_min_n;
      dip_tau_q <= dip_tau_n;
      g_min_q   <= g_min_n;
      g_tau_q   <= g_tau_n;
      g_seen_q  <= g_seen_n;
    end
  end

  // Output registers: one-cycle pulse, tau/voiced held until the next window.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tau_out       <= '0;
      tau_valid_out <= 1'b0;
      voiced_out    <= 1'b0;
    end else begin
      tau_valid_out <= emit;
      if (emit) begin
        tau_out    <= emit_tau;
        voiced_out <= emit_voiced;
      end
    end
  end

endmodule

// File: tb/tb_yin_tau_picker.sv
// Scoreboard bench for yin_tau_picker: driver queues expected periods, monitor checks each pulse.
module tb_yin_tau_picker;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [39:0] diff_in = '0;
  logic        diff_valid_in = 1'b0;
  logic        diff_last_in = 1'b0;
  logic [10:0] tau_out;
  logic        tau_valid_out;
  logic        voiced_out;

  typedef struct {
    logic [10:0] tau;
    logic        voiced;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  yin_tau_picker #(
    .DIFF_WIDTH (40),
    .TAU_MIN    (20),
    .THRESH     (38)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .diff_in       (diff_in),
    .diff_valid_in (diff_valid_in),
    .diff_last_in  (diff_last_in),
    .tau_out       (tau_out),
    .tau_valid_out (tau_valid_out),
    .voiced_out    (voiced_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard, including its cycle.
  always @(negedge clk_in) begin
    if (rst_in && tau_valid_out) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got tau=%0d voiced=%0d expected no pulse", tau_out, voiced_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tau", int'(tau_out), int'(e.tau));
        check("voiced", int'(voiced_out), int'(e.voiced));
        check("latency", cyc, e.cyc);
      end
    end
  end

  // Hand-chosen d(t) profiles for each scenario.
  function automatic logic [39:0] gen_d(input int unsigned s, input int unsigned t);
    case (s)
      1: return (t == 100) ? 40'd10 : (t == 101) ? 40'd5 : (t == 102) ? 40'd20 : 40'd1000;
      2: return (t == 300) ? 40'd900 : 40'd1000;
      3: return 40'd0;
      4: return (t == 2047) ? 40'd0 : 40'd1000;
      5: return (t <= 2047) ? 40'd1000 : 40'd0;
      default: return 40'd1000;
    endcase
  endfunction

  // Drives one window; called with time at posedge+1, returns at posedge+1.
  task automatic run_window(input int unsigned n, input int unsigned s,
                            input int unsigned exp_tau, input logic exp_voiced,
                            input int unsigned idle);
    for (int unsigned t = 1; t <= n; t++) begin
      diff_in       = gen_d(s, t);
      diff_valid_in = 1'b1;
      diff_last_in  = (t == n);
      if (t == n) sb.push_back('{tau: 11'(exp_tau), voiced: exp_voiced, cyc: cyc + 3});
      @(posedge clk_in);
      #1;
    end
    diff_last_in = 1'b0;
    if (idle > 0) begin
      diff_valid_in = 1'b0;
      repeat (idle) @(posedge clk_in);
      #1;
    end
  endtask

  initial begin
    #12;
    check("rst_tau", int'(tau_out), 0);
    check("rst_valid", int'(tau_valid_out), 0);
    check("rst_voiced", int'(voiced_out), 0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Dip at lags 100..102, deepest at 101.
    run_window(1024, 1, 101, 1'b1, 5);

    // Reset part-way through a window: nothing emitted, outputs cleared.
    for (int unsigned t = 1; t <= 500; t++) begin
      diff_in       = 40'd1000;
      diff_valid_in = 1'b1;
      @(posedge clk_in);
      #1;
    end
    diff_valid_in = 1'b0;
    rst_in = 1'b0;
    #2;
    check("midrst_tau", int'(tau_out), 0);
    check("midrst_valid", int'(tau_valid_out), 0);
    check("midrst_voiced", int'(voiced_out), 0);
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;

    // Fresh window after reset starts at t=1 again.
    run_window(1024, 1, 101, 1'b1, 5);
    // No lag under threshold: global minimum at 300.
    run_window(400, 2, 300, 1'b0, 5);
    // Silence: all zero, first lag >= TAU_MIN wins.
    run_window(2047, 3, 20, 1'b0, 5);
    // Dip on the final, saturating lag.
    run_window(2047, 4, 2047, 1'b1, 5);
    // Beats past 2047 are ignored even though their d=0 would dip.
    run_window(2050, 5, 20, 1'b0, 5);
    // Window shorter than TAU_MIN.
    run_window(10, 6, 20, 1'b0, 5);
    // Back-to-back windows with zero idle cycles.
    run_window(1024, 1, 101, 1'b1, 0);
    run_window(400, 2, 300, 1'b0, 5);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk_in);
    #1;
    check("pending_pulses", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
